esc_ctrl: RTL and testbench
===========================

// Module: esc_ctrl
// PURPOSE
//  Arming/command sequencer for a bank of NCH esc PWM generators (400 Hz, 10-bit cmd).
//  Buffers host commands, releases them only on PWM frame boundaries, enforces an
//  arming hold at zero throttle and a command watchdog with failsafe.
//  Sits between the flight-control command source and the esc instances, on the same
//  1 MHz tick domain.
// PARAMETERS
//  NCH         4     number of ESC channels
//  FRAME_US    2500  ticks per PWM frame; must match the esc period
//  ARM_FRAMES  800   consecutive zero-throttle frames required to arm (2 s)
//  WDOG_FRAMES 40    frames without an accepted command before failsafe (100 ms)
//  SLEW_STEP   16    maximum per-frame cmd increase (ESC_SLEW_EN only)
// PORTS
//  tmr_1Mhz   in   1       1 MHz clock; all logic on its rising edge
//  rst        in   1       synchronous, active-high reset
//  arm_req    in   1       level; 1 = request armed, 0 = disarm
//  cmd_in     in   10*NCH  channel k occupies bits [10k+9:10k]
//  cmd_valid  in   1       cmd_in valid
//  cmd_ready  out  1       shadow register can accept cmd_in
//  frame_tick out  1       1-cycle pulse in last tick of each frame
//  cmd_out    out  10*NCH  registered commands to esc[k].cmd
//  armed      out  1       1 in ARMED only
//  fault      out  1       1 in FAILSAFE only
// BEHAVIOUR
//  - Reset: state DISARMED; frm_ctr, arm_ctr, wd_ctr, shadow all 0; cmd_out=0;
//    armed=0; fault=0; frame_tick=0; cmd_ready=1. Reset mid-operation aborts any state.
//  - frm_ctr counts 0..FRAME_US-1 and wraps; frame_tick is registered and high
//    exactly when frm_ctr==FRAME_US-1.
//  - Handshake: cmd_ready = ~frame_tick. Transfer on cmd_valid&&cmd_ready
//    -> shadow<=cmd_in next edge, wd_ctr<=0. Last transfer before the tick wins.
//    The tick cycle cannot accept, so no transfer/commit collision exists.
//  - cmd_out changes only on the edge after frame_tick (commit), or on disarm/failsafe.
//  - Transitions are evaluated every cycle; frame counters advance on frame_tick:
//    DISARMED: cmd_out=0. arm_req=1 && all shadow==0 -> ARMING, arm_ctr=0.
//    ARMING:   cmd_out=0. arm_req=0 -> DISARMED. Any shadow!=0 -> arm_ctr=0.
//      Otherwise arm_ctr++ per tick; tick with arm_ctr==ARM_FRAMES-1 -> ARMED, wd_ctr=0.
//    ARMED:    commit at each tick. arm_req=0 -> DISARMED, cmd_out=0 next edge.
//      wd_ctr++ per tick with no transfer, saturating. Tick with wd_ctr==WDOG_FRAMES-1
//      -> FAILSAFE; cmd_out=0 on the same edge.
//    FAILSAFE: cmd_out=0, fault=1. Stays until arm_req=0 -> DISARMED (fault clears).
//      A re-arm requires a fresh arming hold.
//  - Same cycle arm_req=0 and watchdog expiry in ARMED: DISARMED wins, fault stays 0.
//  - wd_ctr counts only in ARMED and is held at 0 otherwise.
// CONFIGURATION
//  ESC_SLEW_EN defined: per channel at commit, if shadow>cmd_out then
//    cmd_out <= min(cmd_out+SLEW_STEP, shadow). Compute in 11 bits; result never
//    exceeds 1023. If shadow<=cmd_out, cmd_out <= shadow immediately
//    (decreases never limited).
//  ESC_SLEW_EN undefined: cmd_out <= shadow at commit; SLEW_STEP is ignored.
// TESTING (override ARM_FRAMES=4, WDOG_FRAMES=3, FRAME_US=50)
//  1 rst; arm_req=1, cmds 0 -> ARMING; armed=1 on the edge after the 4th frame_tick,
//    not before.
//  2 In ARMING, load ch1=100 after 2 frames -> arm_ctr restarts; load 0, then 4 more
//    ticks -> armed=1.
//  3 ARMED, ch0=500 loaded at frm_ctr=10 -> cmd_out[9:0] stays at old value until the
//    edge after the next tick, then 500.
//  3b cmd_valid held during the frame_tick cycle -> cmd_ready=0, no capture.
//  4 ARMED, no transfers for 3 ticks -> fault=1, cmd_out=0, armed=0; arm_req=0 ->
//    fault=0, DISARMED.
//  5 ESC_SLEW_EN, ch0 0->100 -> commits 16,32,48,64,80,96,100.
//    Then 100->0 -> 0 on the next commit. Without the macro: 100 on the first commit.
//  6 rst pulsed while ARMED with cmd_out=700 -> next edge: cmd_out=0, armed=0, fault=0,
//    frm_ctr=0.

Source files
------------

// File: rtl/esc_ctrl.sv
// esc_ctrl -- arming / command sequencer for a bank of NCH ESC PWM generators.
//
// Host commands are buffered in a shadow register and released to the ESCs
// only on PWM frame boundaries (the edge after frame_tick). Arming requires a
// sustained hold of all-zero commands; once armed, a command watchdog forces
// FAILSAFE (outputs zeroed) if the host stops sending. All logic runs on the
// 1 MHz tick clock.
//
// Ports:
//   tmr_1Mhz   in   1 MHz clock, rising edge
//   rst        in   synchronous active-high reset
//   arm_req    in   level: 1 = request armed, 0 = disarm
//   cmd_in     in   10*NCH, channel k in bits [10k+9:10k]
//   cmd_valid  in   cmd_in valid
//   cmd_ready  out  shadow can accept (low only during the frame_tick cycle)
//   frame_tick out  1-cycle pulse in the last tick of each frame
//   cmd_out    out  10*NCH registered commands to the ESCs
//   armed      out  1 in ARMED only
//   fault      out  1 in FAILSAFE only
//
// Optional feature macro: ESC_SLEW_EN -- limits per-frame command increases
// to SLEW_STEP; decreases are always applied immediately.

module esc_ctrl_lane #(
  parameter int SLEW_STEP = 16
) (
  input  logic [9:0] shadow,
  input  logic [9:0] cur,
  output logic [9:0] nxt
);
`ifdef ESC_SLEW_EN
  // 11-bit sum so cur+SLEW_STEP cannot wrap before the compare
  logic [10:0] sum;
  always_comb begin
    sum = {1'b0, cur} + 11'(SLEW_STEP);
    nxt = shadow;
    if (shadow > cur && sum < {1'b0, shadow}) nxt = sum[9:0];
  end
`else
  logic unused_lane;
  assign unused_lane = ^{cur, 11'(SLEW_STEP)};
  assign nxt = shadow;
`endif
endmodule

module esc_ctrl #(
  parameter int NCH         = 4,
  parameter int FRAME_US    = 2500,
  parameter int ARM_FRAMES  = 800,
  parameter int WDOG_FRAMES = 40,
  parameter int SLEW_STEP   = 16
) (
  input  logic              tmr_1Mhz,
  input  logic              rst,
  input  logic              arm_req,
  input  logic [10*NCH-1:0] cmd_in,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  output logic              frame_tick,
  output logic [10*NCH-1:0] cmd_out,
  output logic              armed,
  output logic              fault
);
  localparam int FW = (FRAME_US    > 2) ? $clog2(FRAME_US)    : 1;
  localparam int AW = (ARM_FRAMES  > 2) ? $clog2(ARM_FRAMES)  : 1;
  localparam int WW = (WDOG_FRAMES > 2) ? $clog2(WDOG_FRAMES) : 1;

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMING   = 2'd1,
    ST_ARMED    = 2'd2,
    ST_FAILSAFE = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [FW-1:0]           frm_ctr_q, frm_ctr_d;
  logic [AW-1:0]           arm_ctr_q, arm_ctr_d;
  logic [WW-1:0]           wd_ctr_q, wd_ctr_d;
  logic                    frame_tick_q, frame_tick_d;
  logic                    armed_q, armed_d;
  logic                    fault_q, fault_d;
  logic [NCH-1:0][9:0]     shadow_q, shadow_d;
  logic [NCH-1:0][9:0]     cmd_q, cmd_d;
  logic [NCH-1:0][9:0]     cmd_in_a;
  logic [NCH-1:0][9:0]     commit_val;
  logic                    xfer;
  logic                    shadow_zero;

  assign cmd_in_a   = cmd_in;
  assign cmd_ready  = ~frame_tick_q;
  assign frame_tick = frame_tick_q;
  assign cmd_out    = cmd_q;
  assign armed      = armed_q;
  assign fault      = fault_q;

  // Per-channel commit value (slew-limited when enabled)
  for (genvar g = 0; g < NCH; g++) begin : g_lane
    esc_ctrl_lane #(.SLEW_STEP(SLEW_STEP)) u_lane (
      .shadow (shadow_q[g]),
      .cur    (cmd_q[g]),
      .nxt    (commit_val[g])
    );
  end

  always_comb begin
    state_d   = state_q;
    arm_ctr_d = arm_ctr_q;
    wd_ctr_d  = wd_ctr_q;
    cmd_d     = cmd_q;

    frm_ctr_d = (frm_ctr_q == FW'(FRAME_US - 1)) ? '0 : frm_ctr_q + FW'(1);
    // Registered tick: high while frm_ctr_q sits at FRAME_US-1
    frame_tick_d = (frm_ctr_d == FW'(FRAME_US - 1));

    // Tick cycle never accepts, so a transfer never coincides with a commit
    xfer        = cmd_valid && !frame_tick_q;
    shadow_d    = xfer ? cmd_in_a : shadow_q;
    shadow_zero = (shadow_q == '0);

    case (state_q)
      ST_DISARMED: begin
        cmd_d     = '0;
        arm_ctr_d = '0;
        wd_ctr_d  = '0;
        if (arm_req && shadow_zero) state_d = ST_ARMING;
      end
      ST_ARMING: begin
        cmd_d    = '0;
        wd_ctr_d = '0;
        if (!arm_req) begin
          state_d   = ST_DISARMED;
          arm_ctr_d = '0;
        end else if (!shadow_zero) begin
          arm_ctr_d = '0;
        end else if (frame_tick_q) begin
          if (arm_ctr_q == AW'(ARM_FRAMES - 1)) begin
            state_d   = ST_ARMED;
            arm_ctr_d = '0;
          end else begin
            arm_ctr_d = arm_ctr_q + AW'(1);
          end
        end
      end
      ST_ARMED: begin
        arm_ctr_d = '0;
        // Disarm has priority over a coincident watchdog expiry
        if (!arm_req) begin
          state_d  = ST_DISARMED;
          cmd_d    = '0;
          wd_ctr_d = '0;
        end else if (frame_tick_q) begin
          if (wd_ctr_q == WW'(WDOG_FRAMES - 1)) begin
            state_d  = ST_FAILSAFE;
            cmd_d    = '0;
            wd_ctr_d = '0;
          end else begin
            cmd_d = commit_val;
            if (wd_ctr_q != '1) wd_ctr_d = wd_ctr_q + WW'(1);
          end
        end else if (xfer) begin
          wd_ctr_d = '0;
        end
      end
      ST_FAILSAFE: begin
        cmd_d     = '0;
        arm_ctr_d = '0;
        wd_ctr_d  = '0;
        if (!arm_req) state_d = ST_DISARMED;
      end
      default: begin
        state_d   = ST_DISARMED;
        cmd_d     = '0;
        arm_ctr_d = '0;
        wd_ctr_d  = '0;
      end
    endcase

    armed_d = (state_d == ST_ARMED);
    fault_d = (state_d == ST_FAILSAFE);
  end

  always_ff @(posedge tmr_1Mhz) begin
    if (rst) begin
      state_q      <= ST_DISARMED;
      frm_ctr_q    <= '0;
      arm_ctr_q    <= '0;
      wd_ctr_q     <= '0;
      frame_tick_q <= 1'b0;
      armed_q      <= 1'b0;
      fault_q      <= 1'b0;
      shadow_q     <= '0;
      cmd_q        <= '0;
    end else begin
      state_q      <= state_d;
      frm_ctr_q    <= frm_ctr_d;
      arm_ctr_q    <= arm_ctr_d;
      wd_ctr_q     <= wd_ctr_d;
      frame_tick_q <= frame_tick_d;
      armed_q      <= armed_d;
      fault_q      <= fault_d;
      shadow_q     <= shadow_d;
      cmd_q        <= cmd_d;
    end
  end
endmodule

// File: tb/tb_esc_ctrl.sv
// Scoreboard bench for esc_ctrl with FRAME_US=50, ARM_FRAMES=4, WDOG_FRAMES=3.
// k = number of rising edges since the first reset edge; frm_ctr == k mod 50
// until the mid-run reset at k=1161. Expectations are queued per phase and
// checked by an independent negedge monitor at their cycle.
module tb_esc_ctrl;
  localparam int NCH = 4;
  localparam int FR  = 50;
  localparam int RST2 = 1161;
`ifdef ESC_SLEW_EN
  localparam bit SLEW = 1'b1;
`else
  localparam bit SLEW = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              arm_req;
  logic [10*NCH-1:0] cmd_in;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              frame_tick;
  logic [10*NCH-1:0] cmd_out;
  logic              armed;
  logic              fault;

  always #5 clk = ~clk;

  esc_ctrl #(.NCH(NCH), .FRAME_US(FR), .ARM_FRAMES(4), .WDOG_FRAMES(3), .SLEW_STEP(16)) dut (
    .tmr_1Mhz   (clk),
    .rst        (rst),
    .arm_req    (arm_req),
    .cmd_in     (cmd_in),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .frame_tick (frame_tick),
    .cmd_out    (cmd_out),
    .armed      (armed),
    .fault      (fault)
  );

  typedef struct {
    int          cyc;
    string       nm;
    logic [39:0] cmd;
    logic        arm;
    logic        flt;
    logic        tick;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  int   base = 2;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [39:0] pk(int c0, int c1, int c2, int c3);
    return {10'(c3), 10'(c2), 10'(c1), 10'(c0)};
  endfunction

  task automatic expect_at(int k, string nm, logic [39:0] cmd, logic arm, logic flt);
    exp_t x;
    int rel;
    rel    = (k >= RST2) ? k - RST2 : k;
    x.cyc  = base + k;
    x.nm   = nm;
    x.cmd  = cmd;
    x.arm  = arm;
    x.flt  = flt;
    x.tick = ((rel % FR) == FR - 1);
    q.push_back(x);
  endtask

  task automatic go(int k);
    while (cyc < base + k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Inputs set after edge k are captured at edge k+1
  task automatic send(int k, logic [39:0] d);
    go(k);
    cmd_in    = d;
    cmd_valid = 1'b1;
    go(k + 1);
    cmd_valid = 1'b0;
    cmd_in    = '0;
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      n_tests++;
      if (e.cyc != cyc || cmd_out !== e.cmd || armed !== e.arm || fault !== e.flt ||
          frame_tick !== e.tick || cmd_ready !== !e.tick) begin
        n_fail++;
        $display("FAIL %s k=%0d: got cmd=%h armed=%b fault=%b tick=%b ready=%b, want cmd=%h armed=%b fault=%b tick=%b ready=%b",
                 e.nm, cyc - base, cmd_out, armed, fault, frame_tick, cmd_ready,
                 e.cmd, e.arm, e.flt, e.tick, !e.tick);
      end
    end
    if (done) begin
      while (q.size() > 0) begin
        e = q.pop_front();
        n_tests++;
        n_fail++;
        $display("FAIL %s: got no sample, want check at k=%0d", e.nm, e.cyc - base);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of stimulus, want finish within 200us");
    $fatal(1, "timeout");
  end

  function automatic int slew_val(int f);
    int v;
    v = 16 * (f + 1);
    if (v > 100) v = 100;
    return SLEW ? v : 100;
  endfunction

  initial begin
    rst       = 1'b1;
    arm_req   = 1'b1;
    cmd_valid = 1'b0;
    cmd_in    = '0;

    // Reset, frame timing, arming hold of 4 ticks
    expect_at(0,   "reset",          '0, 0, 0);
    expect_at(48,  "pre_tick",       '0, 0, 0);
    expect_at(49,  "first_tick",     '0, 0, 0);
    expect_at(50,  "tick_clear",     '0, 0, 0);
    expect_at(199, "not_armed_yet",  '0, 0, 0);
    expect_at(200, "armed_4th_tick", '0, 1, 0);
    go(0);
    rst = 1'b0;

    // Frame-aligned commit, tick-cycle refusal, watchdog failsafe, disarm
    expect_at(250, "commit_zero",    '0, 1, 0);
    expect_at(299, "hold_old",       '0, 1, 0);
    expect_at(300, "commit_500",     pk(500,0,0,0), 1, 0);
    expect_at(349, "tick_hold_500",  pk(500,0,0,0), 1, 0);
    expect_at(350, "no_tick_cap",    pk(500,0,0,0), 1, 0);
    expect_at(399, "pre_wdog",       pk(500,0,0,0), 1, 0);
    expect_at(400, "wdog_failsafe",  '0, 0, 1);
    expect_at(410, "failsafe_hold",  '0, 0, 1);
    expect_at(411, "disarm_clear",   '0, 0, 0);
    send(260, pk(500,0,0,0));
    go(299);
    cmd_in    = pk(300,0,0,0);
    cmd_valid = 1'b1;
    go(300);
    cmd_valid = 1'b0;
    cmd_in    = '0;
    go(410);
    arm_req = 1'b0;

    // Arming hold restarted by a nonzero shadow
    expect_at(515, "arming_out0",    '0, 0, 0);
    expect_at(600, "restart_noarm",  '0, 0, 0);
    expect_at(699, "restart_noarm2", '0, 0, 0);
    expect_at(700, "rearmed",        '0, 1, 0);
    send(415, '0);
    go(420);
    arm_req = 1'b1;
    send(510, pk(0,100,0,0));
    send(520, '0);

    // Commit sequence 0 -> 100 (slew-limited when enabled), then 100 -> 0
    for (int f = 0; f < 7; f++) begin
      expect_at(749 + 50*f, "pre_commit", pk((f == 0) ? 0 : slew_val(f-1),0,0,0), 1, 0);
      expect_at(750 + 50*f, "ramp_commit", pk(slew_val(f),0,0,0), 1, 0);
    end
    expect_at(1099, "pre_drop",      pk(100,0,0,0), 1, 0);
    expect_at(1100, "drop_to_0",     '0, 1, 0);
    expect_at(1150, "commit_700",    pk(SLEW ? 16 : 700,0,5,0), 1, 0);
    expect_at(1161, "reset_midrun",  '0, 0, 0);
    expect_at(1209, "frm_restart",   '0, 0, 0);
    expect_at(1210, "tick_after_rst",'0, 0, 0);
    expect_at(1360, "rearm_pending", '0, 0, 0);
    expect_at(1361, "rearm_after_rst",'0, 1, 0);
    for (int f = 0; f < 7; f++) send(710 + 50*f, pk(100,0,0,0));
    send(1060, '0);
    send(1110, pk(700,0,5,0));
    go(1160);
    rst = 1'b1;
    go(1161);
    rst = 1'b0;
    go(1370);
    done = 1'b1;
  end
endmodule
